// File: rtl/pipe_arith_hs.sv
// F = ((a+b)+(c-d))*d, three registered stages, valid/ready with combinational ready chain (bubble collapsing).
// Latency 3 cycles, 1 beat/cycle; a stalled stage holds data and valid. Optional clamp via `PIPE_ARITH_SAT_EN.
module pipe_arith_hs #(
  parameter int N = 10,
  localparam int FW = 2*N+3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [N-1:0]  c,
  input  logic [N-1:0]  d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-1:0] out_f,
  output logic          out_sat,
  output logic          busy
);

  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [N:0]    x1_q, x1_d;
  logic [N:0]    x2_q, x2_d;
  logic [N-1:0]  d1_q, d1_d;
  logic [N+2:0]  x3_q, x3_d;
  logic [N-1:0]  d2_q, d2_d;
  logic [FW-1:0] f_q, f_d;
  logic          sat_q, sat_d;

  logic r1, r2, r3;
  logic ld1, ld2, ld3;
  logic signed [FW-1:0] x3_w, d_w, prod;

  always_comb begin
    r3 = !v3_q | out_ready;
    r2 = !v2_q | r3;
    r1 = !v1_q | r2;
    ld1 = r1 & in_valid & !flush;
    ld2 = r2 & v1_q & !flush;
    ld3 = r3 & v2_q & !flush;
  end

  always_comb begin
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end else begin
      v1_d = r1 ? in_valid : v1_q;
      v2_d = r2 ? v1_q : v2_q;
      v3_d = r3 ? v2_q : v3_q;
    end
  end

  // x2 and x3 are two's complement; plain modular adds give the right bits.
  always_comb begin
    x1_d = x1_q;
    x2_d = x2_q;
    d1_d = d1_q;
    if (ld1) begin
      x1_d = {1'b0, a} + {1'b0, b};
      x2_d = {1'b0, c} - {1'b0, d};
      d1_d = d;
    end
    x3_d = x3_q;
    d2_d = d2_q;
    if (ld2) begin
      x3_d = {2'b00, x1_q} + {{2{x2_q[N]}}, x2_q};
      d2_d = d1_q;
    end
  end

  always_comb begin
    x3_w = $signed({{N{x3_q[N+2]}}, x3_q});
    d_w  = $signed({{(N+3){1'b0}}, d2_q});
    prod = x3_w * d_w;
  end

`ifdef PIPE_ARITH_SAT_EN
  localparam logic signed [FW-1:0] SAT_MAX = $signed({{(N+3){1'b0}}, {N{1'b1}}});

  always_comb begin
    f_d   = f_q;
    sat_d = sat_q;
    if (ld3) begin
      if (prod[FW-1]) begin
        f_d   = '0;
        sat_d = 1'b1;
      end else if (prod > SAT_MAX) begin
        f_d   = SAT_MAX;
        sat_d = 1'b1;
      end else begin
        f_d   = prod;
        sat_d = 1'b0;
      end
    end
  end
`else
  always_comb begin
    f_d   = f_q;
    sat_d = 1'b0;
    if (ld3) begin
      f_d = prod;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      x1_q  <= '0;
      x2_q  <= '0;
      d1_q  <= '0;
      x3_q  <= '0;
      d2_q  <= '0;
      f_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      x1_q  <= x1_d;
      x2_q  <= x2_d;
      d1_q  <= d1_d;
      x3_q  <= x3_d;
      d2_q  <= d2_d;
      f_q   <= f_d;
      sat_q <= sat_d;
    end
  end

  assign in_ready  = r1;
  assign out_valid = v3_q;
  assign out_f     = f_q;
  assign out_sat   = sat_q;
  assign busy      = v1_q | v2_q | v3_q;

endmodule
